// File: rtl/race_controller_if.sv
// Track-side inputs and lap-timer/dashboard outputs of the race controller.
// The slave modport is the controller's view; master is the driver/observer side.
interface race_controller_if #(
    parameter int unsigned N_CP = 4
);
    logic            start_btn;
    logic            pause_btn;
    logic            finish_cross;
    logic [N_CP-1:0] checkpoint_hit;
    logic            max_time_exceeded;

    logic            timer_start;
    logic            timer_stop;
    logic            timer_lap_finished;
    logic            timer_checkpoints_passed;
    logic [2:0]      lights;
    logic [3:0]      lap_count;
    logic [2:0]      race_state;
    logic            race_done;

    modport master (
        output start_btn, pause_btn, finish_cross, checkpoint_hit, max_time_exceeded,
        input  timer_start, timer_stop, timer_lap_finished, timer_checkpoints_passed,
        input  lights, lap_count, race_state, race_done
    );

    modport slave (
        input  start_btn, pause_btn, finish_cross, checkpoint_hit, max_time_exceeded,
        output timer_start, timer_stop, timer_lap_finished, timer_checkpoints_passed,
        output lights, lap_count, race_state, race_done
    );
endinterface

// File: rtl/race_controller.sv
// Race sequencer for one car: countdown lights, start, pause/resume,
// per-lap checkpoint validation and finish, driving the lap timer controls.
module race_controller #(
    parameter int unsigned N_CP          = 4,
    parameter int unsigned LAPS          = 3,
    parameter int unsigned TICKS_PER_SEC = 65_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic            pclk,
    input  logic            rst_n,
    race_controller_if.slave bus
);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [3:0]       LAPS_MAX  = 4'(LAPS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RACING    = 3'd2,
        S_LAP_END   = 3'd3,
        S_PAUSED    = 3'd4,
        S_FINISHED  = 3'd5
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] tick_cnt;
    logic [N_CP-1:0] cp_mask;
    logic            lap_valid;
    logic            timer_start;
    logic            timer_stop;
    logic            timer_lap_finished;
    logic            timer_cp_passed;
    logic [2:0]      lights;
    logic [3:0]      lap_count;
    logic            race_done;

    logic [N_CP-1:0] cp_all;
    logic [3:0]      lap_next;

    // Hits arriving in the crossing cycle still count; lap count saturates at LAPS.
    always_comb begin
        cp_all   = cp_mask | bus.checkpoint_hit;
        lap_next = lap_count;
        if (lap_valid && (lap_count < LAPS_MAX)) begin
            lap_next = lap_count + 4'd1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            tick_cnt           <= '0;
            cp_mask            <= '0;
            lap_valid          <= 1'b0;
            timer_start        <= 1'b0;
            timer_stop         <= 1'b0;
            timer_lap_finished <= 1'b0;
            timer_cp_passed    <= 1'b0;
            lights             <= 3'b000;
            lap_count          <= 4'd0;
            race_done          <= 1'b0;
        end else begin
            timer_start        <= 1'b0;
            timer_stop         <= 1'b0;
            timer_lap_finished <= 1'b0;
            timer_cp_passed    <= 1'b0;

            case (state)
                S_IDLE, S_FINISHED: begin
                    if (bus.start_btn) begin
                        state     <= S_COUNTDOWN;
                        lights    <= 3'b111;
                        lap_count <= 4'd0;
                        cp_mask   <= '0;
                        tick_cnt  <= '0;
                        race_done <= 1'b0;
                    end
                end

                // Each full second drops one light; the last drop launches the race.
                S_COUNTDOWN: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        lights   <= {1'b0, lights[2:1]};
                        if (lights == 3'b001) begin
                            state       <= S_RACING;
                            timer_start <= 1'b1;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + CNT_W'(1);
                    end
                end

                S_RACING: begin
                    cp_mask <= cp_all;
                    if (bus.finish_cross) begin
                        timer_lap_finished <= 1'b1;
                        timer_cp_passed    <= &cp_all;
                        lap_valid          <= (&cp_all) & ~bus.max_time_exceeded;
                        state              <= S_LAP_END;
                    end else if (bus.pause_btn) begin
                        timer_stop <= 1'b1;
                        state      <= S_PAUSED;
                    end
                end

                // Checkpoint verdict stays visible for one more cycle while the lap is booked.
                S_LAP_END: begin
                    cp_mask         <= '0;
                    timer_cp_passed <= timer_cp_passed;
                    lap_count       <= lap_next;
                    if (lap_next == LAPS_MAX) begin
                        state      <= S_FINISHED;
                        timer_stop <= 1'b1;
                        race_done  <= 1'b1;
                    end else begin
                        state <= S_RACING;
                    end
                end

                S_PAUSED: begin
                    if (bus.pause_btn) begin
                        timer_start <= 1'b1;
                        state       <= S_RACING;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.timer_start              = timer_start;
    assign bus.timer_stop               = timer_stop;
    assign bus.timer_lap_finished       = timer_lap_finished;
    assign bus.timer_checkpoints_passed = timer_cp_passed;
    assign bus.lights                   = lights;
    assign bus.lap_count                = lap_count;
    assign bus.race_state               = state;
    assign bus.race_done                = race_done;
endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
- Sequences the lap timer for one car: countdown lights, race start, pause/resume, lap validation and race finish.
- Tracks checkpoint hits per lap and drives the timer's start, stop, lap_finished and checkpoints_passed inputs.
- Counts valid laps and sits between the track/collision logic and the lap timer.

Parameters:
N_CP, 4, number of track checkpoints
LAPS, 3, valid laps needed to finish the race (1..15)
TICKS_PER_SEC, 65_000_000, pclk cycles per countdown step
CNT_W, 27, countdown tick counter width (must hold TICKS_PER_SEC-1)

Ports:
pclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_btn  in  1  single-cycle pulse; starts or restarts the race
pause_btn  in  1  single-cycle pulse; toggles pause
finish_cross  in  1  single-cycle pulse; car crossed the start/finish line
checkpoint_hit  in  N_CP  single-cycle pulses; bit i means checkpoint i was reached
max_time_exceeded  in  1  from the lap timer; current lap is void
timer_start  out  1  pulse to lap timer start
timer_stop  out  1  pulse to lap timer stop
timer_lap_finished  out  1  pulse to lap timer lap_finished
timer_checkpoints_passed  out  1  level to lap timer checkpoints_passed
lights  out  3  countdown lights, 1 = lit
lap_count  out  4  valid laps completed
race_state  out  3  IDLE=0, COUNTDOWN=1, RACING=2, LAP_END=3, PAUSED=4, FINISHED=5
race_done  out  1  high while in FINISHED

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; all outputs 0; cp_mask 0; tick counter 0.
- All outputs are registered. Pulses last exactly 1 cycle.
- IDLE: start_btn -> COUNTDOWN. Lights 111, lap_count 0, cp_mask 0, tick counter 0.
- COUNTDOWN:
  - Tick counter counts 0..TICKS_PER_SEC-1, then wraps.
  - Each wrap shifts the lights: 111 -> 011 -> 001 -> 000.
  - The wrap that produces 000 also enters RACING with timer_start=1.
  - RACING is therefore entered exactly 3*TICKS_PER_SEC cycles after the COUNTDOWN entry edge.
  - All other inputs are ignored in COUNTDOWN.
- RACING:
  - checkpoint_hit bits OR into cp_mask (sticky, any order).
  - finish_cross:
    - timer_lap_finished=1 and timer_checkpoints_passed=&(cp_mask|checkpoint_hit), so hits in the same cycle count.
    - lap_valid = that AND NOT max_time_exceeded.
    - Go to LAP_END.
  - pause_btn without finish_cross -> PAUSED, timer_stop=1.
  - finish_cross and pause_btn together: the crossing wins and pause is dropped.
- LAP_END (1 cycle):
  - timer_lap_finished=0; timer_checkpoints_passed holds its value.
  - cp_mask cleared; inputs ignored.
  - If lap_valid, lap_count increments.
  - If the new count == LAPS -> FINISHED with timer_stop=1; else -> RACING.
  - timer_checkpoints_passed returns to 0 on the following cycle.
- PAUSED:
  - pause_btn -> RACING with timer_start=1.
  - cp_mask is kept; checkpoint_hit and finish_cross are ignored.
- FINISHED: race_done=1; lap_count holds; start_btn -> COUNTDOWN (same entry actions as from IDLE).
- start_btn outside IDLE/FINISHED is ignored.
- lap_count saturates at LAPS.
- rst_n asserted in any state returns everything to reset values immediately, with no stop pulse.

Test Plan:
1. TICKS_PER_SEC=4, start_btn at edge k -> lights 111 from k; 011 at k+4; 001 at k+8; 000, race_state=2 and timer_start=1 at k+12 only.
2. RACING, hit checkpoints 0..3, then finish_cross -> timer_lap_finished 1 cycle, timer_checkpoints_passed high 2 cycles, lap_count 0->1, cp_mask cleared.
3. Hit checkpoints 0,1,3 only, then finish_cross -> timer_checkpoints_passed=0, lap_count unchanged, state back to RACING.
4. LAPS=3, three valid laps -> third LAP_END gives timer_stop=1, race_state=5, race_done=1, lap_count=3; a later finish_cross has no effect.
5. pause_btn and finish_cross in the same cycle -> lap processed, no timer_stop; next pause_btn -> PAUSED with timer_stop; pause_btn again -> timer_start and RACING.
6. max_time_exceeded=1 with all checkpoints hit, then finish_cross -> lap_count unchanged; rst_n low mid-LAP_END -> all outputs 0 asynchronously.
